spi_read_seq: RTL and testbench
===============================

SPI_READ_SEQ -- requirements
Module: spi_read_seq

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, giving the SCLK half-period in clk cycles (legal range 1..255).
REQ-002 SHALL have parameter CMD, default 8'h03, the read opcode sent first.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: a read request is present.
REQ-006 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-007 SHALL have port req_addr, input, 24 bits: flash byte address, sampled on accept.
REQ-008 SHALL have port req_len, input, 8 bits: byte count, sampled on accept; 0 means 256.
REQ-009 SHALL have port sclk, output, 1 bit: SPI clock, mode 0 (idles low).
REQ-010 SHALL have port cs_n, output, 1 bit: active-low chip select.
REQ-011 SHALL have port mosi, output, 1 bit: serial data to the flash.
REQ-012 SHALL have port miso, input, 1 bit: serial data from the flash.
REQ-013 SHALL have port rd_valid, output, 1 bit: rd_data holds a received byte.
REQ-014 SHALL have port rd_data, output, 8 bits: received byte, first bit received in bit 7.
REQ-015 SHALL have port rd_ready, input, 1 bit: the consumer accepts rd_data.
REQ-016 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-017 SHALL implement the states IDLE, CMD, ADDR, DATA and HOLD.
REQ-018 SHALL drive req_ready=1 only in IDLE; accept = req_valid & req_ready.
REQ-019 SHALL, on accept, move to CMD on the next cycle with cs_n=0, sclk=0, and mosi=CMD[7].
REQ-020 SHALL form each bit as CLK_DIV cycles with sclk low, then CLK_DIV cycles with sclk high.
REQ-021 SHALL change mosi only while sclk is low (at bit start) and sample miso on the cycle sclk goes 0->1.
REQ-022 SHALL shift out CMD (8 bits) in CMD, then req_addr (24 bits) in ADDR, MSB first, with no gap between bits.
REQ-023 SHALL hold mosi=0 in DATA and shift in 8*len bits (len = 256 when req_len is 0).
REQ-024 SHALL, on the 8th miso sample of a byte, load rd_data and set rd_valid=1 on the next cycle.
REQ-025 SHALL hold rd_valid and rd_data stable until rd_valid & rd_ready, then clear rd_valid on the next cycle.
REQ-026 SHALL block the first sclk rise of the next byte while rd_valid=1 and rd_ready=0; during this stall sclk stays 0 and no sample is taken.
REQ-027 SHALL, when rd_ready=1 in the same cycle the next byte would rise, let that rise proceed with no stall (single holding register).
REQ-028 SHALL enter HOLD after the final data bit's sclk-high phase, with cs_n=1 and sclk=0.
REQ-029 SHALL stay in HOLD for CLK_DIV cycles and until rd_valid=0, then return to IDLE.
REQ-030 SHALL use a byte counter at least 9 bits wide so that 256 bytes is reached without wrap-around.
REQ-031 SHALL ignore req_valid while busy, and later requests SHALL NOT alter the captured address or length.

Reset
REQ-032 SHALL, while rst_n=0 at a clk edge, force IDLE with cs_n=1, sclk=0, mosi=0, rd_valid=0, rd_data=0, busy=0, req_ready=1 on the following cycle.
REQ-033 SHALL, on reset mid-transfer, end the transfer at once with cs_n=1, drop any pending byte, and produce no further rd_valid.

Verification
REQ-034 SHALL verify: CLK_DIV=2, addr=24'h123456, len=1, miso byte 8'hA5, rd_ready=1 -> mosi bits 03,12,34,56; one rd_valid with rd_data=8'hA5; cs_n low for exactly 40 bits (160 cycles).
REQ-035 SHALL verify: len=3, rd_ready=0 for 20 cycles after the first rd_valid -> sclk held low for the whole stall; bytes 2 and 3 arrive intact and in order.
REQ-036 SHALL verify: len=0 -> exactly 256 rd_valid handshakes, then HOLD, then IDLE.
REQ-037 SHALL verify: rst_n=0 in the middle of ADDR -> next cycle cs_n=1, sclk=0, rd_valid=0, req_ready=1; a new request then completes normally.
REQ-038 SHALL verify: req_valid kept high through a transfer with a changing req_addr -> only one transfer, using the address captured at accept; the second request is accepted only in IDLE.
REQ-039 SHALL verify: CLK_DIV=1, len=2, rd_ready pulsed high in the cycle before the next byte's sclk rise -> no stall, sclk period 2 cycles throughout.

Source files
------------

// File: rtl/spi_read_seq.sv
// SPI NOR read sequencer (mode 0). It sends the read opcode and a 24-bit address,
// then streams len bytes back through a single-entry rd_valid/rd_ready holding register.
//
// state   | meaning
// IDLE    | no transfer; req_ready high
// CMD     | shifting out the 8-bit read opcode
// ADDR    | shifting out the 24-bit byte address, MSB first
// DATA    | clocking in data bytes; mosi held low
// HOLD    | cs_n high; waits the deselect time and for the last byte to drain
module spi_read_seq #(
  parameter int unsigned CLK_DIV = 2,
  parameter logic [7:0]  CMD     = 8'h03
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_len,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  input  logic        rd_ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_HOLD
  } state_t;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        sclk_q, sclk_d;
  logic [4:0]  bit_q, bit_d;
  logic [31:0] tx_q, tx_d;
  logic [8:0]  byte_q, byte_d;
  logic [6:0]  rx_q, rx_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;

  logic in_xfer;
  logic div_tc;
  logic accept;
  logic stall;

  assign in_xfer = (state_q == ST_CMD) || (state_q == ST_ADDR) || (state_q == ST_DATA);
  assign div_tc  = (div_q == 8'd0);
  assign accept  = req_valid && (state_q == ST_IDLE);
  // The first rise of a byte waits until the holding register has room.
  assign stall   = (state_q == ST_DATA) && !sclk_q && div_tc && (bit_q == 5'd7) &&
                   rd_valid_q && !rd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      div_q      <= 8'd0;
      sclk_q     <= 1'b0;
      bit_q      <= 5'd0;
      tx_q       <= 32'd0;
      byte_q     <= 9'd0;
      rx_q       <= 7'd0;
      rd_data_q  <= 8'd0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      sclk_q     <= sclk_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      byte_q     <= byte_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    sclk_d     = sclk_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    byte_d     = byte_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q && !rd_ready;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_CMD;
          tx_d    = {CMD, req_addr};
          byte_d  = (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
          bit_d   = 5'd7;
          div_d   = DIV_LOAD;
          sclk_d  = 1'b0;
        end
      end

      ST_CMD, ST_ADDR, ST_DATA: begin
        if (!div_tc) begin
          div_d = div_q - 8'd1;
        end else if (!sclk_q) begin
          if (!stall) begin
            sclk_d = 1'b1;
            div_d  = DIV_LOAD;
            if (state_q == ST_DATA) begin
              rx_d = {rx_q[5:0], miso};
              if (bit_q == 5'd0) begin
                rd_data_d  = {rx_q, miso};
                rd_valid_d = 1'b1;
              end
            end
          end
        end else begin
          // End of the high phase closes the bit.
          sclk_d = 1'b0;
          div_d  = DIV_LOAD;
          tx_d   = {tx_q[30:0], 1'b0};
          bit_d  = bit_q - 5'd1;
          if (bit_q == 5'd0) begin
            case (state_q)
              ST_CMD: begin
                state_d = ST_ADDR;
                bit_d   = 5'd23;
              end
              ST_ADDR: begin
                state_d = ST_DATA;
                bit_d   = 5'd7;
              end
              default: begin
                bit_d = 5'd7;
                if (byte_q == 9'd1) begin
                  state_d = ST_HOLD;
                end else begin
                  byte_d = byte_q - 9'd1;
                end
              end
            endcase
          end
        end
      end

      ST_HOLD: begin
        if (!div_tc) begin
          div_d = div_q - 8'd1;
        end else if (!rd_valid_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign sclk      = sclk_q;
  assign cs_n      = !in_xfer;
  assign mosi      = ((state_q == ST_CMD) || (state_q == ST_ADDR)) ? tx_q[31] : 1'b0;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_spi_read_seq.sv
// Bench for spi_read_seq: table of read transfers on a CLK_DIV=2 instance against a
// small flash model, plus stall, reset, busy-ignore and CLK_DIV=1 sequences.
module tb_spi_read_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        rst_n, req_valid, req_ready, sclk, cs_n, mosi, miso, rd_valid, rd_ready, busy;
  logic [23:0] req_addr;
  logic [7:0]  req_len, rd_data;

  logic        req_valid_b, req_ready_b, sclk_b, cs_n_b, mosi_b, miso_b;
  logic        rd_valid_b, rd_ready_b, busy_b;
  logic [23:0] req_addr_b;
  logic [7:0]  req_len_b, rd_data_b;

  spi_read_seq #(.CLK_DIV(2), .CMD(8'h03)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready), .busy(busy)
  );

  spi_read_seq #(.CLK_DIV(1), .CMD(8'h03)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_addr(req_addr_b), .req_len(req_len_b), .sclk(sclk_b), .cs_n(cs_n_b), .mosi(mosi_b),
    .miso(miso_b), .rd_valid(rd_valid_b), .rd_data(rd_data_b), .rd_ready(rd_ready_b),
    .busy(busy_b)
  );

  function automatic logic [7:0] exp_byte(input int j);
    return 8'(j * 37 + 11);
  endfunction

  // Flash returns b0 as byte 0 and exp_byte(j) for later bytes; bit k follows k sclk rises.
  function automatic logic flash_bit(input int k, input logic [7:0] b0);
    logic [7:0] b;
    int p;
    if (k < 32) return 1'b0;
    p = k - 32;
    b = (p / 8 == 0) ? b0 : exp_byte(p / 8);
    return b[7 - (p % 8)];
  endfunction

  // Instance A monitor
  int          rise_cnt = 0, cs_low_tot = 0, hold_tot = 0, hs_tot = 0, acc_tot = 0, acc_bad = 0;
  logic        prev_sclk = 1'b0;
  logic [31:0] mosi_word = 32'd0;
  logic [7:0]  got_mem [4096];
  logic [7:0]  resp0 = 8'h00;

  assign miso = flash_bit(rise_cnt, resp0);

  always @(negedge clk) begin
    prev_sclk <= sclk;
    if (!cs_n) cs_low_tot <= cs_low_tot + 1;
    if (busy && cs_n) hold_tot <= hold_tot + 1;
    if (cs_n) begin
      rise_cnt <= 0;
    end else if (sclk && !prev_sclk) begin
      rise_cnt <= rise_cnt + 1;
      if (rise_cnt < 32) mosi_word <= {mosi_word[30:0], mosi};
    end
    if (rd_valid && rd_ready) begin
      got_mem[hs_tot[11:0]] <= rd_data;
      hs_tot <= hs_tot + 1;
    end
    if (req_valid && req_ready) acc_tot <= acc_tot + 1;
    if (req_valid && req_ready && busy) acc_bad <= acc_bad + 1;
  end

  // Instance B monitor
  int         rise_b = 0, cs_low_b = 0, hs_b = 0, notog_b = 0;
  logic       prev_sclk_b = 1'b0, prev_cs_b = 1'b1;
  logic [7:0] got_b [4];

  assign miso_b = flash_bit(rise_b, 8'h3C);

  always @(negedge clk) begin
    prev_sclk_b <= sclk_b;
    prev_cs_b   <= cs_n_b;
    if (!cs_n_b) cs_low_b <= cs_low_b + 1;
    if (!cs_n_b && !prev_cs_b && (sclk_b == prev_sclk_b)) notog_b <= notog_b + 1;
    if (cs_n_b) rise_b <= 0;
    else if (sclk_b && !prev_sclk_b) rise_b <= rise_b + 1;
    if (rd_valid_b && rd_ready_b) begin
      got_b[hs_b[1:0]] <= rd_data_b;
      hs_b <= hs_b + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n;
    n = 0;
    while (busy && n < limit) begin
      tick;
      n++;
    end
    chk(name, busy, 1'b0);
  endtask

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  len;
    logic [7:0]  b0;
    logic [31:0] exp_word;
    int          exp_cs;
    int          exp_hs;
  } vec_t;

  vec_t vecs [6];

  task automatic run_vec(input vec_t v, input string tag);
    int cs0, hd0, hs0, n, idx;
    cs0 = cs_low_tot;
    hd0 = hold_tot;
    hs0 = hs_tot;
    resp0 = v.b0;
    req_addr = v.addr;
    req_len = v.len;
    req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    wait_idle(20000, {tag, "_idle"});
    chk({tag, "_mosi"}, mosi_word, v.exp_word);
    chk({tag, "_cs_cycles"}, cs_low_tot - cs0, v.exp_cs);
    chk({tag, "_rd_count"}, hs_tot - hs0, v.exp_hs);
    chk({tag, "_hold_cycles"}, hold_tot - hd0, 2);
    n = (hs_tot - hs0 < v.exp_hs) ? hs_tot - hs0 : v.exp_hs;
    for (int j = 0; j < n; j++) begin
      idx = hs0 + j;
      chk($sformatf("%s_byte%0d", tag, j), got_mem[idx[11:0]], (j == 0) ? v.b0 : exp_byte(j));
    end
  endtask

  initial begin
    int n, bad, hs0, cs0, base, idx;

    vecs[0] = '{24'h123456, 8'd1, 8'hA5, 32'h03123456, 160, 1};
    vecs[1] = '{24'hABCDEF, 8'd2, 8'h5A, 32'h03ABCDEF, 192, 2};
    vecs[2] = '{24'h000000, 8'd4, 8'hFF, 32'h03000000, 256, 4};
    vecs[3] = '{24'hFFFFFF, 8'd1, 8'h00, 32'h03FFFFFF, 160, 1};
    vecs[4] = '{24'h800001, 8'd3, 8'h81, 32'h03800001, 224, 3};
    vecs[5] = '{24'h0A0B0C, 8'd0, 8'h3E, 32'h030A0B0C, 8320, 256};

    rst_n = 1'b0; req_valid = 1'b0; req_addr = 24'd0; req_len = 8'd0; rd_ready = 1'b1;
    req_valid_b = 1'b0; req_addr_b = 24'd0; req_len_b = 8'd0; rd_ready_b = 1'b0;
    repeat (3) tick;
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    rst_n = 1'b1;
    tick;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Consumer holds rd_ready low for 20 cycles after the first byte.
    hs0 = hs_tot;
    rd_ready = 1'b0;
    resp0 = 8'hC6;
    req_addr = 24'h00ABCD; req_len = 8'd3; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    n = 0;
    while (!rd_valid && n < 1000) begin tick; n++; end
    chk("stall_first_valid", rd_valid, 1'b1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i >= 2 && sclk) bad++;
      tick;
    end
    chk("stall_sclk_low", bad, 0);
    chk("stall_no_rise", rise_cnt, 40);
    chk("stall_hold_data", rd_data, 8'hC6);
    chk("stall_hold_valid", rd_valid, 1'b1);
    rd_ready = 1'b1;
    wait_idle(2000, "stall_idle");
    chk("stall_count", hs_tot - hs0, 3);
    for (int j = 0; j < 3; j++) begin
      idx = hs0 + j;
      chk($sformatf("stall_byte%0d", j), got_mem[idx[11:0]], (j == 0) ? 8'hC6 : exp_byte(j));
    end

    // Reset in the middle of the address phase.
    hs0 = hs_tot;
    resp0 = 8'h00;
    req_addr = 24'h13579B; req_len = 8'd2; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    n = 0;
    while (rise_cnt < 12 && n < 500) begin tick; n++; end
    chk("midrst_in_addr", (rise_cnt >= 12) && !cs_n, 1'b1);
    rst_n = 1'b0;
    tick;
    chk("midrst_cs_n", cs_n, 1'b1);
    chk("midrst_sclk", sclk, 1'b0);
    chk("midrst_rd_valid", rd_valid, 1'b0);
    chk("midrst_req_ready", req_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick;
    chk("midrst_no_bytes", hs_tot - hs0, 0);
    run_vec(vecs[0], "after_rst");

    // req_valid held through a transfer while address and length wander.
    base = acc_tot;
    hs0 = hs_tot;
    resp0 = 8'h77;
    req_addr = 24'h0F1E2D; req_len = 8'd2; req_valid = 1'b1;
    tick;
    n = 0;
    while (!(busy && cs_n) && n < 2000) begin
      req_addr = 24'($urandom);
      req_len = 8'($urandom);
      tick;
      n++;
    end
    chk("ign_reach_hold", busy && cs_n, 1'b1);
    chk("ign_single_accept", acc_tot - base, 1);
    chk("ign_mosi", mosi_word, 32'h030F1E2D);
    chk("ign_count", hs_tot - hs0, 2);
    req_addr = 24'h654321; req_len = 8'd1;
    n = 0;
    while (acc_tot - base < 2 && n < 100) begin tick; n++; end
    chk("ign_second_accept", acc_tot - base, 2);
    req_valid = 1'b0;
    wait_idle(2000, "ign_idle2");
    chk("ign_mosi2", mosi_word, 32'h03654321);
    chk("ign_count2", hs_tot - hs0, 3);
    chk("ign_accept_while_busy", acc_bad, 0);

    // CLK_DIV=1 instance: rd_ready pulsed in the cycle before the next byte's rise.
    hs0 = hs_b;
    cs0 = cs_low_b;
    base = notog_b;
    req_addr_b = 24'h2468AC; req_len_b = 8'd2; req_valid_b = 1'b1;
    tick;
    req_valid_b = 1'b0;
    n = 0;
    while (!rd_valid_b && n < 500) begin tick; n++; end
    chk("div1_first_valid", rd_valid_b, 1'b1);
    tick;
    chk("div1_low_before_rise", sclk_b, 1'b0);
    rd_ready_b = 1'b1;
    tick;
    rd_ready_b = 1'b0;
    chk("div1_rise_no_stall", sclk_b, 1'b1);
    n = 0;
    while (!rd_valid_b && n < 500) begin tick; n++; end
    chk("div1_second_valid", rd_valid_b, 1'b1);
    rd_ready_b = 1'b1;
    n = 0;
    while (busy_b && n < 500) begin tick; n++; end
    chk("div1_idle", busy_b, 1'b0);
    chk("div1_cs_cycles", cs_low_b - cs0, 96);
    chk("div1_sclk_toggle", notog_b - base, 0);
    chk("div1_count", hs_b - hs0, 2);
    chk("div1_byte0", got_b[0], 8'h3C);
    chk("div1_byte1", got_b[1], exp_byte(1));
    chk("div1_mosi_idle", mosi_b, 1'b0);
    chk("div1_req_ready", req_ready_b, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
